// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - Bin, one 2-bit digit per clock, LSB first.
// Start/done handshake with a registered borrow chain between digits.
module digit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic             zero
);

    localparam int D  = WIDTH / 2;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic [2:0]       sub;

    // Operands shift right each digit so the active digit is always bits [1:0].
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        sub     = {1'b0, a_q[1:0]} - {1'b0, b_q[1:0]} - {2'b00, br_q};

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 2;
                b_d   = b_q >> 2;
                br_d  = sub[2];
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < D; i++) begin
                    if (cnt_q == CW'(i)) begin
                        diff_d[2*i +: 2] = sub[1:0];
                    end
                end
                if (cnt_q == CW'(D - 1)) begin
                    bout_d  = sub[2];
                    zero_d  = (diff_d == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign Bout = bout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed bench for digit_serial_subtractor: WIDTH=8 directed cases plus
// an exhaustive WIDTH=2 sweep, results checked through expectation queues.
module tb_digit_serial_subtractor;

    typedef struct packed {
        logic [7:0] diff;
        logic       bout;
        logic       zero;
    } exp8_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8, zero8;
    logic [7:0] diff8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       bin2 = 1'b0;
    logic       busy2, done2, bout2, zero2;
    logic [1:0] diff2;

    int tests = 0;
    int fails = 0;
    int busyc = 0;
    exp8_t      sb8[$];
    logic [3:0] sb2[$];

    always #5 clk = ~clk;

    digit_serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .a(a8), .b(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8),
        .Bout(bout8), .zero(zero8)
    );

    digit_serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .a(a2), .b(b2), .Bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2),
        .Bout(bout2), .zero(zero2)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and consume the accept edge; operands are then scrambled.
    task automatic start_op8(input logic [7:0] a, input logic [7:0] b,
                             input logic bin);
        logic [8:0] r;
        exp8_t e;
        r = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        e.diff = r[7:0];
        e.bout = r[8];
        e.zero = (r[7:0] == 8'd0);
        sb8.push_back(e);
        a8 = a;
        b8 = b;
        bin8 = bin;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        bin8 = 1'($urandom);
        busyc = busy8 ? 1 : 0;
    endtask

    task automatic finish_op8(input string tag, input bit intrude);
        int n;
        exp8_t e;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n = i;
            if (intrude && i == 1) begin
                a8 = 8'hFF;
                b8 = 8'h00;
                start8 = 1'b1;
            end
            if (intrude && i == 2) start8 = 1'b0;
            if (done8) break;
            if (busy8) busyc++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_busy_cycles"}, busyc, 4);
        e = sb8.pop_front();
        check({tag, "_diff"}, diff8, e.diff);
        check({tag, "_bout"}, bout8, e.bout);
        check({tag, "_zero"}, zero8, e.zero);
    endtask

    initial begin
        int seen;
        logic [2:0] r3;
        logic [3:0] e2;

        #2;
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_outs8", {diff8, bout8, zero8}, 0);
        check("rst_outs2", {busy2, done2, diff2, bout2, zero2}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        start_op8(8'hF0, 8'h0F, 1'b0);
        tick();
        tick();
        check("mid_diff_nonzero", (diff8 != 0), 1);
        rst_n = 1'b0;
        #1;
        check("abort_outs", {busy8, done8, diff8, bout8, zero8}, 0);
        sb8.delete();
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done8 || busy8) seen++;
        end
        check("abort_no_done", seen, 0);

        start_op8(8'd200, 8'd55, 1'b0);
        finish_op8("basic", 1'b0);
        tick();
        check("done_pulse", done8, 0);
        check("diff_hold", diff8, 8'd145);

        start_op8(8'd0, 8'd0, 1'b1);
        finish_op8("under_bin", 1'b0);
        tick();
        start_op8(8'd3, 8'd10, 1'b0);
        finish_op8("under", 1'b0);
        tick();
        start_op8(8'hA5, 8'hA4, 1'b1);
        finish_op8("zero", 1'b0);
        tick();

        start_op8(8'd100, 8'd30, 1'b0);
        finish_op8("intrude", 1'b1);
        check("b2b_hold", diff8, 8'd70);
        start_op8(8'd9, 8'd4, 1'b0);
        check("b2b_accept_hold", diff8, 8'd70);
        finish_op8("b2b", 1'b0);
        tick();

        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = i[4:0];
            r3 = {1'b0, v[1:0]} - {1'b0, v[3:2]} - {2'b00, v[4]};
            sb2.push_back({r3, (r3[1:0] == 2'b00)});
            a2 = v[1:0];
            b2 = v[3:2];
            bin2 = v[4];
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            check("w2_busy", {busy2, done2}, 2'b10);
            tick();
            check("w2_done", {busy2, done2}, 2'b01);
            e2 = sb2.pop_front();
            check($sformatf("w2_res_%0d", i), {bout2, diff2, zero2}, e2);
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
